// File: rtl/msg_sram_loader.sv
// msg_sram_loader: packs a valid/ready byte stream into 64-bit message-SRAM words and publishes m_len/enable
//   clk, srst_n     : clock, synchronous active-low reset
//   start           : pulse that begins a new message and aborts any message in progress
//   byte_valid/data/last, byte_ready : host byte stream handshake
//   sram_wen/waddr/wdata             : registered word write port
//   m_len           : stored byte count, saturating at 2^MAX_MLEN_BW-1
//   enable          : message complete, SRAM contents and m_len are valid
//   overflow        : sticky, bytes beyond capacity were dropped
//   MSG_LOADER_LE_EN: when defined, byte k of a word lands in bits [8k+7:8k] instead of [63-8k -: 8]
module msg_sram_loader #(
   parameter int MAX_MLEN_BW      = 14,
   parameter int MSG_SRAM_ADDR_BW = MAX_MLEN_BW - 3
) (
   input  logic                        clk,
   input  logic                        srst_n,
   input  logic                        start,
   input  logic                        byte_valid,
   input  logic [7:0]                  byte_data,
   input  logic                        byte_last,
   output logic                        byte_ready,
   output logic                        sram_wen,
   output logic [MSG_SRAM_ADDR_BW-1:0] sram_waddr,
   output logic [63:0]                 sram_wdata,
   output logic [MAX_MLEN_BW-1:0]      m_len,
   output logic                        enable,
   output logic                        overflow
);
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
   state_t state, state_nxt;
   logic [63:0] pack, word;
   logic [2:0] lane;
   logic [5:0] shift;
   logic [MSG_SRAM_ADDR_BW-1:0] addr;
   logic accept, full, store;
   // start wins over a byte presented in the same cycle
   assign accept = state == LOAD && byte_valid && !start;
   assign full = &m_len;
   assign store = accept && !full;
`ifdef MSG_LOADER_LE_EN
   assign shift = {lane, 3'b000};
`else
   assign shift = {~lane, 3'b000};
`endif
   // current pack register with the incoming byte merged into its lane
   assign word = pack | (64'(byte_data) << shift);
   always_ff @(posedge clk) begin
      if (!srst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      if (start) state_nxt = LOAD;
      else if (accept && byte_last) state_nxt = FLUSH;
      else if (state == FLUSH) state_nxt = DONE;
      byte_ready = state == LOAD;
      enable = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         sram_wen   <= 1'b0;
         sram_waddr <= '0;
         sram_wdata <= '0;
         m_len      <= '0;
         overflow   <= 1'b0;
         lane       <= '0;
         addr       <= '0;
         pack       <= '0;
      end else begin
         sram_wen <= 1'b0;
         if (start) begin
            m_len    <= '0;
            overflow <= 1'b0;
            lane     <= '0;
            addr     <= '0;
            pack     <= '0;
         end else if (accept) begin
            if (full) overflow <= 1'b1;
            else begin
               m_len <= m_len + 1'b1;
               lane  <= lane + 1'b1;
               pack  <= lane == 3'd7 ? '0 : word;
               if (lane == 3'd7) addr <= addr + 1'b1;
            end
            // a stored byte filling lane 7 or ending the message writes the merged word;
            // a dropped final byte flushes whatever partial word is still pending
            if ((store && (lane == 3'd7 || byte_last)) || (!store && byte_last && lane != 3'd0)) begin
               sram_wen   <= 1'b1;
               sram_waddr <= addr;
               sram_wdata <= store ? word : pack;
            end
         end
      end
   end
endmodule
